// File: rtl/kronos_ex_lsu.sv
// kronos_ex_lsu: execute stage with single-cycle ALU write-back, branch resolution and a sequenced load/store unit
module kronos_alu (
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [3:0]  aluop,
    output logic [31:0] result
);
    always_comb begin
        case (aluop)
            4'b0000: result = op1 + op2;
            4'b1000: result = op1 - op2;
            4'b0001: result = op1 << op2[4:0];
            4'b0010: result = {31'd0, $signed(op1) < $signed(op2)};
            4'b0011: result = {31'd0, op1 < op2};
            4'b0100: result = op1 ^ op2;
            4'b0101: result = op1 >> op2[4:0];
            4'b1101: result = $signed(op1) >>> op2[4:0];
            4'b0110: result = op1 | op2;
            4'b0111: result = op1 & op2;
            4'b1001: result = {31'd0, op1 == op2};
            4'b1100: result = {31'd0, op1 != op2};
            4'b1010: result = {31'd0, $signed(op1) >= $signed(op2)};
            4'b1011: result = {31'd0, op1 >= op2};
            default: result = 32'd0;
        endcase
    end
endmodule

module kronos_ex_lsu #(
    parameter int MISALIGN_CHECK = 1,
    parameter int MEM_TIMEOUT    = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] decode_op1,
    input  logic [31:0] decode_op2,
    input  logic [3:0]  decode_aluop,
    input  logic [4:0]  decode_rd,
    input  logic        decode_regwr_alu,
    input  logic        decode_branch,
    input  logic        decode_branch_cond,
    input  logic [31:0] decode_addr,
    input  logic        decode_load,
    input  logic        decode_store,
    input  logic [1:0]  decode_size,
    input  logic        decode_unsigned,
    input  logic [31:0] decode_wdata,
    input  logic        decode_vld,
    output logic        decode_rdy,
    output logic [31:0] regwr_data,
    output logic [4:0]  regwr_sel,
    output logic        regwr_en,
    output logic [31:0] branch_target,
    output logic        branch,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_mask,
    output logic        data_wr_en,
    output logic        data_req,
    input  logic        data_ack,
    input  logic [31:0] data_rdata,
    output logic        exc_misaligned,
    output logic        exc_bus_timeout,
    output logic [31:0] exc_addr
);
    typedef enum logic {STEADY, MEM} state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  off_q, off_d, size_q, size_d;
    logic        uns_q, uns_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] regwr_data_q, regwr_data_d;
    logic [4:0]  regwr_sel_q, regwr_sel_d;
    logic        regwr_en_q, regwr_en_d;
    logic [31:0] data_addr_q, data_addr_d;
    logic [31:0] data_wdata_q, data_wdata_d;
    logic [3:0]  data_mask_q, data_mask_d;
    logic        data_wr_en_q, data_wr_en_d;
    logic        data_req_q, data_req_d;
    logic        exc_mis_q, exc_mis_d;
    logic        exc_to_q, exc_to_d;
    logic [31:0] exc_addr_q, exc_addr_d;
    logic [31:0] result, shifted, load_val;
    logic [3:0]  base_mask;
    logic        accept, mis;

    kronos_alu u_alu (
        .op1    (decode_op1),
        .op2    (decode_op2),
        .aluop  (decode_aluop),
        .result (result)
    );

    assign decode_rdy      = state_q == STEADY;
    assign accept          = decode_vld & decode_rdy;
    assign mis             = (decode_size == 2'd1 & result[0]) | (decode_size == 2'd2 & result[1:0] != 2'b00);
    assign branch          = accept & (decode_branch | (decode_branch_cond & result[0]));
    assign branch_target   = decode_addr;
    assign base_mask       = decode_size == 2'd0 ? 4'b0001 : decode_size == 2'd1 ? 4'b0011 : 4'b1111;
    assign shifted         = data_rdata >> {off_q, 3'b000};
    assign load_val        = size_q == 2'd0 ? {{24{~uns_q & shifted[7]}}, shifted[7:0]} :
                             size_q == 2'd1 ? {{16{~uns_q & shifted[15]}}, shifted[15:0]} : shifted;
    assign regwr_data      = regwr_data_q;
    assign regwr_sel       = regwr_sel_q;
    assign regwr_en        = regwr_en_q;
    assign data_addr       = data_addr_q;
    assign data_wdata      = data_wdata_q;
    assign data_mask       = data_mask_q;
    assign data_wr_en      = data_wr_en_q;
    assign data_req        = data_req_q;
    assign exc_misaligned  = exc_mis_q;
    assign exc_bus_timeout = exc_to_q;
    assign exc_addr        = exc_addr_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        off_d        = off_q;
        size_d       = size_q;
        uns_d        = uns_q;
        rd_d         = rd_q;
        regwr_data_d = regwr_data_q;
        regwr_sel_d  = regwr_sel_q;
        regwr_en_d   = 1'b0;
        data_addr_d  = data_addr_q;
        data_wdata_d = data_wdata_q;
        data_mask_d  = data_mask_q;
        data_wr_en_d = data_wr_en_q;
        data_req_d   = data_req_q;
        exc_mis_d    = 1'b0;
        exc_to_d     = 1'b0;
        exc_addr_d   = exc_addr_q;
        if (state_q == STEADY) begin
            if (accept && (decode_load || decode_store)) begin
                if (mis && MISALIGN_CHECK != 0) begin
                    exc_mis_d  = 1'b1;
                    exc_addr_d = result;
                end else begin
                    state_d      = MEM;
                    cnt_d        = 32'd0;
                    data_req_d   = 1'b1;
                    data_addr_d  = {result[31:2], 2'b00};
                    data_wr_en_d = decode_store;
                    data_mask_d  = base_mask << result[1:0];
                    data_wdata_d = decode_wdata << {result[1:0], 3'b000};
                    off_d        = result[1:0];
                    size_d       = decode_size;
                    uns_d        = decode_unsigned;
                    rd_d         = decode_rd;
                end
            end else if (accept && decode_regwr_alu) begin
                regwr_en_d   = 1'b1;
                regwr_sel_d  = decode_rd;
                regwr_data_d = result;
            end
        end else if (data_ack) begin
            state_d    = STEADY;
            data_req_d = 1'b0;
            if (!data_wr_en_q) begin
                regwr_en_d   = 1'b1;
                regwr_sel_d  = rd_q;
                regwr_data_d = load_val;
            end
        end else if (MEM_TIMEOUT > 0 && cnt_q == 32'(MEM_TIMEOUT - 1)) begin
            state_d    = STEADY;
            data_req_d = 1'b0;
            exc_to_d   = 1'b1;
            exc_addr_d = data_addr_q;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= STEADY;
            cnt_q        <= '0;
            off_q        <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            rd_q         <= '0;
            regwr_data_q <= '0;
            regwr_sel_q  <= '0;
            regwr_en_q   <= 1'b0;
            data_addr_q  <= '0;
            data_wdata_q <= '0;
            data_mask_q  <= '0;
            data_wr_en_q <= 1'b0;
            data_req_q   <= 1'b0;
            exc_mis_q    <= 1'b0;
            exc_to_q     <= 1'b0;
            exc_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            off_q        <= off_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            rd_q         <= rd_d;
            regwr_data_q <= regwr_data_d;
            regwr_sel_q  <= regwr_sel_d;
            regwr_en_q   <= regwr_en_d;
            data_addr_q  <= data_addr_d;
            data_wdata_q <= data_wdata_d;
            data_mask_q  <= data_mask_d;
            data_wr_en_q <= data_wr_en_d;
            data_req_q   <= data_req_d;
            exc_mis_q    <= exc_mis_d;
            exc_to_q     <= exc_to_d;
            exc_addr_q   <= exc_addr_d;
        end
    end
endmodule

// File: tb/tb_kronos_ex_lsu.sv
// tb_kronos_ex_lsu: vector table, directed corner sequences and randomized ALU/LSU traffic against a reference model
module tb_kronos_ex_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] decode_op1, decode_op2, decode_addr, decode_wdata;
    logic [3:0]  decode_aluop;
    logic [4:0]  decode_rd;
    logic        decode_regwr_alu, decode_branch, decode_branch_cond;
    logic        decode_load, decode_store, decode_unsigned, decode_vld;
    logic [1:0]  decode_size;
    logic        decode_rdy;
    logic [31:0] regwr_data, branch_target, data_addr, data_wdata, data_rdata, exc_addr;
    logic [4:0]  regwr_sel;
    logic        regwr_en, branch, data_wr_en, data_req, data_ack;
    logic [3:0]  data_mask;
    logic        exc_misaligned, exc_bus_timeout;
    int          n_cmp = 0;
    int          n_err = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[10];

    kronos_ex_lsu #(.MISALIGN_CHECK(1), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .decode_op1(decode_op1), .decode_op2(decode_op2), .decode_aluop(decode_aluop),
        .decode_rd(decode_rd), .decode_regwr_alu(decode_regwr_alu), .decode_branch(decode_branch),
        .decode_branch_cond(decode_branch_cond), .decode_addr(decode_addr), .decode_load(decode_load),
        .decode_store(decode_store), .decode_size(decode_size), .decode_unsigned(decode_unsigned),
        .decode_wdata(decode_wdata), .decode_vld(decode_vld), .decode_rdy(decode_rdy),
        .regwr_data(regwr_data), .regwr_sel(regwr_sel), .regwr_en(regwr_en),
        .branch_target(branch_target), .branch(branch), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_mask(data_mask), .data_wr_en(data_wr_en),
        .data_req(data_req), .data_ack(data_ack), .data_rdata(data_rdata),
        .exc_misaligned(exc_misaligned), .exc_bus_timeout(exc_bus_timeout), .exc_addr(exc_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        decode_op1 = 0; decode_op2 = 0; decode_aluop = 0; decode_rd = 0;
        decode_regwr_alu = 0; decode_branch = 0; decode_branch_cond = 0; decode_addr = 0;
        decode_load = 0; decode_store = 0; decode_size = 0; decode_unsigned = 0;
        decode_wdata = 0; decode_vld = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] m_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        logic [31:0] r;
        case (op)
            0:  r = a + b;
            8:  r = a - b;
            1:  r = a << b[4:0];
            2:  r = ($signed(a) < $signed(b)) ? 1 : 0;
            3:  r = (a < b) ? 1 : 0;
            4:  r = a ^ b;
            5:  r = a >> b[4:0];
            13: r = $signed(a) >>> b[4:0];
            6:  r = a | b;
            7:  r = a & b;
            9:  r = (a == b) ? 1 : 0;
            12: r = (a != b) ? 1 : 0;
            10: r = ($signed(a) >= $signed(b)) ? 1 : 0;
            11: r = (a >= b) ? 1 : 0;
            default: r = 0;
        endcase
        return r;
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return sz == 0 ? 1 : sz == 1 ? 2 : 4;
    endfunction

    function automatic logic [3:0] m_mask(input int n, input int off);
        logic [3:0] m = 0;
        for (int i = 0; i < 4; i++) m[i] = (i >= off) && (i < off + n);
        return m;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] w, input int off);
        logic [31:0] r = 0;
        for (int i = 0; i < 4; i++) if (i >= off) r[8*i +: 8] = w[8*(i-off) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] d, input int n, input int off, input logic uns);
        logic [31:0] v = 0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = d[8*(off+k) +: 8];
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
        return v;
    endfunction

    task automatic mem_op(input logic ld, input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd,
                          input logic uns, input logic [4:0] rd, input int dly, input logic [31:0] rdat);
        int off = int'(addr[1:0]);
        int n = nbytes(sz);
        decode_op1 = addr; decode_op2 = 0; decode_aluop = 0;
        decode_load = ld; decode_store = !ld; decode_size = sz; decode_unsigned = uns;
        decode_wdata = wd; decode_rd = rd; decode_vld = 1;
        tick();
        decode_vld = 0; decode_load = 0; decode_store = 0;
        chk("mem_req", data_req, 1);
        chk("mem_rdy", decode_rdy, 0);
        chk("mem_addr", data_addr, {addr[31:2], 2'b00});
        chk("mem_mask", data_mask, m_mask(n, off));
        chk("mem_wr_en", data_wr_en, !ld);
        if (!ld) chk("mem_wdata", data_wdata, m_wdata(wd, off));
        for (int i = 0; i < dly; i++) begin
            tick();
            chk("mem_hold", {data_req, decode_rdy, regwr_en, exc_bus_timeout}, 4'b1000);
        end
        data_ack = 1; data_rdata = rdat;
        tick();
        data_ack = 0; data_rdata = $urandom;
        chk("done_req", data_req, 0);
        chk("done_rdy", decode_rdy, 1);
        chk("done_wb_en", regwr_en, ld);
        if (ld) begin
            chk("done_wb_sel", regwr_sel, rd);
            chk("done_wb_data", regwr_data, m_load(rdat, n, off, uns));
        end
    endtask

    initial begin
        logic [3:0] ops[14] = '{0, 8, 1, 2, 3, 4, 5, 13, 6, 7, 9, 12, 10, 11};
        tbl[0] = '{32'd5, 32'd7, 4'd0, 5'd3, 32'd12};
        tbl[1] = '{32'd5, 32'd7, 4'd8, 5'd4, 32'hFFFFFFFE};
        tbl[2] = '{32'hF0F0F0F0, 32'h0FF00FF0, 4'd7, 5'd5, 32'h00F000F0};
        tbl[3] = '{32'hF0F0F0F0, 32'h0FF00FF0, 4'd6, 5'd6, 32'hFFF0FFF0};
        tbl[4] = '{32'hF0F0F0F0, 32'h0FF00FF0, 4'd4, 5'd7, 32'hFF00FF00};
        tbl[5] = '{32'hFFFFFFFF, 32'd1, 4'd2, 5'd8, 32'd1};
        tbl[6] = '{32'hFFFFFFFF, 32'd1, 4'd3, 5'd9, 32'd0};
        tbl[7] = '{32'h80000000, 32'd4, 4'd13, 5'd10, 32'hF8000000};
        tbl[8] = '{32'h80000000, 32'd4, 4'd5, 5'd11, 32'h08000000};
        tbl[9] = '{32'd1, 32'd31, 4'd1, 5'd31, 32'h80000000};
        idle();
        data_ack = 0; data_rdata = 0;
        rst = 1;
        tick(); tick();
        rst = 0;
        chk("rst_regwr_en", regwr_en, 0);
        chk("rst_regwr_data", regwr_data, 0);
        chk("rst_regwr_sel", regwr_sel, 0);
        chk("rst_bus", {data_req, data_wr_en, data_mask}, 0);
        chk("rst_addr", data_addr, 0);
        chk("rst_wdata", data_wdata, 0);
        chk("rst_exc", {exc_misaligned, exc_bus_timeout}, 0);
        chk("rst_exc_addr", exc_addr, 0);
        chk("rst_rdy", decode_rdy, 1);

        foreach (tbl[i]) begin
            decode_op1 = tbl[i].a; decode_op2 = tbl[i].b; decode_aluop = tbl[i].op;
            decode_rd = tbl[i].rd; decode_regwr_alu = 1; decode_vld = 1;
            tick();
            idle();
            chk("alu_en", regwr_en, 1);
            chk("alu_sel", regwr_sel, tbl[i].rd);
            chk("alu_data", regwr_data, tbl[i].exp);
            tick();
            chk("alu_en_drop", regwr_en, 0);
        end

        decode_branch_cond = 1; decode_addr = 32'h100; decode_aluop = 4'd2;
        decode_op1 = 1; decode_op2 = 2; decode_vld = 1;
        #1;
        chk("br_taken", branch, 1);
        chk("br_target", branch_target, 32'h100);
        decode_op1 = 3;
        #1;
        chk("br_not_taken", branch, 0);
        decode_branch = 1;
        #1;
        chk("br_jump", branch, 1);
        decode_vld = 0;
        #1;
        chk("br_no_vld", branch, 0);
        tick();
        chk("br_no_wb", regwr_en, 0);
        idle();

        mem_op(1, 2'd0, 32'h1003, 0, 0, 5'd12, 3, 32'h80000000);
        chk("lb_const", regwr_data, 32'hFFFFFF80);
        mem_op(0, 2'd1, 32'h2002, 32'h0000ABCD, 0, 5'd0, 1, 0);
        chk("sh_const_wdata", data_wdata, 32'hABCD0000);
        chk("sh_const_mask", data_mask, 4'b1100);

        decode_op1 = 32'h3001; decode_load = 1; decode_size = 2; decode_rd = 5; decode_vld = 1;
        tick();
        idle();
        chk("mis_exc", exc_misaligned, 1);
        chk("mis_addr", exc_addr, 32'h3001);
        chk("mis_no_req", {data_req, regwr_en, decode_rdy}, 3'b001);
        tick();
        chk("mis_pulse", {exc_misaligned, data_req}, 0);
        decode_op1 = 32'h3005; decode_store = 1; decode_size = 1; decode_vld = 1;
        tick();
        idle();
        chk("mis_half", {exc_misaligned, data_req}, 2'b10);
        chk("mis_half_addr", exc_addr, 32'h3005);

        decode_op1 = 32'h4000; decode_load = 1; decode_size = 2; decode_rd = 9; decode_vld = 1;
        tick();
        idle();
        chk("to_req", data_req, 1);
        decode_vld = 1; decode_branch = 1; decode_regwr_alu = 1; decode_rd = 2;
        #1;
        chk("mem_ignore_branch", branch, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            idle();
            chk("to_wait", {data_req, exc_bus_timeout, regwr_en}, 3'b100);
        end
        tick();
        chk("to_exc", {exc_bus_timeout, data_req, regwr_en, decode_rdy}, 4'b1001);
        chk("to_addr", exc_addr, 32'h4000);
        tick();
        chk("to_pulse", exc_bus_timeout, 0);

        decode_op1 = 32'h5004; decode_load = 1; decode_size = 2; decode_rd = 7; decode_vld = 1;
        tick();
        idle();
        tick();
        rst = 1;
        tick();
        rst = 0;
        chk("rst_mem_bus", {data_req, data_wr_en, data_mask, regwr_en, exc_bus_timeout}, 0);
        chk("rst_mem_addr", data_addr, 0);
        chk("rst_mem_rdy", decode_rdy, 1);
        data_ack = 1; data_rdata = 32'h12345678;
        tick();
        data_ack = 0;
        chk("rst_mem_no_wb", regwr_en, 0);

        for (int t = 0; t < 40; t++) begin
            logic [31:0] a = $urandom, b = $urandom;
            logic [3:0] op = ops[$urandom_range(0, 13)];
            logic [4:0] rd = 5'($urandom);
            decode_op1 = a; decode_op2 = b; decode_aluop = op; decode_rd = rd;
            decode_regwr_alu = 1; decode_branch_cond = 1; decode_vld = 1;
            #1;
            chk("rnd_branch", branch, m_alu(a, b, op) & 32'd1);
            tick();
            idle();
            chk("rnd_alu_sel", regwr_sel, rd);
            chk("rnd_alu_data", regwr_data, m_alu(a, b, op));
        end

        for (int t = 0; t < 60; t++) begin
            logic [1:0] sz = 2'($urandom_range(0, 2));
            logic [31:0] addr = $urandom;
            if (sz == 1) addr[0] = 0;
            if (sz == 2) addr[1:0] = 0;
            mem_op(1'($urandom), sz, addr, $urandom, 1'($urandom), 5'($urandom), $urandom_range(0, 3), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/kronos_ex_lsu.md
Name: kronos_ex_lsu

Overview:
Next-generation Kronos execution stage. It keeps the single-cycle ALU write-back path and extends branching with conditional resolution. It adds a sequenced load/store unit that drives a request/acknowledge data bus, with alignment checking and an optional bus timeout. It sits between the ID/EX pipeline register and the register file, data bus and fetch redirect.

Parameters:
MISALIGN_CHECK, 1, 1: misaligned load/store raises exc_misaligned with no bus access; 0: access issued with data_addr[1:0] forced to 0.
MEM_TIMEOUT, 0, 0: wait for data_ack indefinitely; N>0: abort after N cycles in MEM without ack.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
decode_op1  in  32  ALU operand 1 (rs1 / PC)
decode_op2  in  32  ALU operand 2 (imm / rs2)
decode_aluop  in  4  kronos_alu operation
decode_rd  in  5  destination register
decode_regwr_alu  in  1  write ALU result to rd
decode_branch  in  1  unconditional jump
decode_branch_cond  in  1  conditional branch, taken if ALU result[0]
decode_addr  in  32  branch/jump target
decode_load  in  1  load; address = ALU result
decode_store  in  1  store; address = ALU result
decode_size  in  2  0 byte, 1 half, 2 word
decode_unsigned  in  1  zero-extend load
decode_wdata  in  32  store data (rs2), LSB-aligned
decode_vld  in  1  decode valid
decode_rdy  out  1  EX ready
regwr_data  out  32  write-back data
regwr_sel  out  5  write-back register
regwr_en  out  1  write-back strobe
branch_target  out  32  = decode_addr
branch  out  1  redirect fetch
data_addr  out  32  bus address
data_wdata  out  32  lane-aligned store data
data_mask  out  4  byte enables
data_wr_en  out  1  1 store, 0 load
data_req  out  1  bus request
data_ack  in  1  bus acknowledge/complete
data_rdata  in  32  load data, valid with data_ack
exc_misaligned  out  1  one-cycle misalignment pulse
exc_bus_timeout  out  1  one-cycle timeout pulse
exc_addr  out  32  faulting address

Behaviour:
- Reset (rst high at posedge): state=STEADY, timeout counter=0. regwr_en, regwr_sel, regwr_data, data_req, data_wr_en, data_mask, data_addr, data_wdata, exc_misaligned, exc_bus_timeout and exc_addr all reset to 0.
- Reset mid-MEM aborts the access: data_req is 0 after that edge, and no write-back or exception occurs.
- FSM states: STEADY and MEM.
- decode_rdy = (state==STEADY). accept = decode_vld & decode_rdy.
- ALU path: kronos_alu is instantiated combinationally.
  - On accept with decode_regwr_alu: next edge regwr_en=1, regwr_sel=decode_rd, regwr_data=result.
  - Otherwise regwr_en=0 the next edge, except for a load completion (below).
  - Latency is 1 cycle.
- Branch is combinational: branch = accept & (decode_branch | (decode_branch_cond & result[0])). branch_target = decode_addr at all times.
- Alignment check on accept of a load/store: off=result[1:0]; mis = (size==1 & off[0]) | (size==2 & off!=0).
  - If mis and MISALIGN_CHECK=1: next edge exc_misaligned=1 for one cycle and exc_addr=result. Stay in STEADY; no bus access, no write-back.
- Bus access on accept of a load/store (not trapped):
  - Next edge: state=MEM, data_req=1, data_addr={result[31:2],2'b00}, data_wr_en=decode_store.
  - Capture off, size, unsigned and rd.
  - data_mask = (size0:4'b0001, size1:4'b0011, size2:4'b1111) << off, truncated to 4 bits.
  - data_wdata = decode_wdata << (8*off).
- MEM: data_req held high and all bus outputs stable until data_ack. The ack may arrive in the first MEM cycle.
- On data_ack (next edge): state=STEADY, data_req=0.
  - Load: regwr_en=1, regwr_sel=captured rd, regwr_data = (data_rdata >> 8*off) masked to size, sign-extended unless unsigned.
  - Store: no write-back.
  - decode_rdy returns the cycle after ack, giving minimum load/store occupancy of 2 cycles.
- Timeout (MEM_TIMEOUT=N>0): counter clears on entry to MEM and increments each MEM cycle without ack.
  - When it reaches N without ack: next edge state=STEADY, data_req=0, exc_bus_timeout=1 for one cycle, exc_addr=data_addr, no write-back.
  - data_ack in the same cycle the count reaches N wins: normal completion, no exception.
- Priority: a store/load flag overrides decode_regwr_alu. The decoder never asserts both.
- decode_vld while in MEM is ignored; no accept occurs.

Test Plan:
- ALU: op1=5, op2=7, ADD, rd=3, regwr_alu, vld=1 -> next cycle regwr_en=1, sel=3, data=12; following cycle regwr_en=0.
- Branch: branch_cond=1 with compare result=1, addr=0x100 -> branch=1 same cycle, target=0x100; with result=0 -> branch=0.
- Load byte signed: addr 0x1003, data_ack after 3 cycles with rdata=0x80000000 -> data_mask=4'b1000, decode_rdy=0 for 4 cycles, regwr_data=0xFFFFFF80.
- Store half at 0x2002, wdata=0xABCD -> data_mask=4'b1100, data_wdata=0xABCD0000, data_wr_en=1, regwr_en stays 0.
- Misaligned word load at 0x3001, MISALIGN_CHECK=1 -> exc_misaligned one cycle, exc_addr=0x3001, data_req never asserts.
- MEM_TIMEOUT=4, no ack -> exc_bus_timeout after 4 MEM cycles, data_req drops. Separately, rst asserted mid-MEM -> all outputs 0 next edge.
